// File: rtl/axi4_lite_regbank_if.sv
// AXI4-Lite bus bundle for the register bank: write address, write data,
// write response, read address and read data channels.
interface axi4_lite_regbank_if #(
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] s_axi_awaddr;
   logic                  s_axi_awvalid;
   logic                  s_axi_awready;
   logic [31:0]           s_axi_wdata;
   logic [3:0]            s_axi_wstrb;
   logic                  s_axi_wvalid;
   logic                  s_axi_wready;
   logic [1:0]            s_axi_bresp;
   logic                  s_axi_bvalid;
   logic                  s_axi_bready;
   logic [ADDR_WIDTH-1:0] s_axi_araddr;
   logic                  s_axi_arvalid;
   logic                  s_axi_arready;
   logic [31:0]           s_axi_rdata;
   logic [1:0]            s_axi_rresp;
   logic                  s_axi_rvalid;
   logic                  s_axi_rready;

   modport master (
      output s_axi_awaddr, s_axi_awvalid, input s_axi_awready,
      output s_axi_wdata, s_axi_wstrb, s_axi_wvalid, input s_axi_wready,
      input s_axi_bresp, s_axi_bvalid, output s_axi_bready,
      output s_axi_araddr, s_axi_arvalid, input s_axi_arready,
      input s_axi_rdata, s_axi_rresp, s_axi_rvalid, output s_axi_rready
   );

   modport slave (
      input s_axi_awaddr, s_axi_awvalid, output s_axi_awready,
      input s_axi_wdata, s_axi_wstrb, s_axi_wvalid, output s_axi_wready,
      output s_axi_bresp, s_axi_bvalid, input s_axi_bready,
      input s_axi_araddr, s_axi_arvalid, output s_axi_arready,
      output s_axi_rdata, s_axi_rresp, s_axi_rvalid, input s_axi_rready
   );
endinterface

// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite slave register bank: NUM_CTRL read/write control words followed
// by NUM_STAT read-only status words. AW and W are buffered independently and
// committed together; pulse-mask bits self-clear one cycle after being set.
module axi4_lite_regbank #(
   parameter int                      ADDR_WIDTH = 8,
   parameter int                      NUM_CTRL   = 4,
   parameter int                      NUM_STAT   = 2,
   parameter logic [NUM_CTRL*32-1:0]  PULSE_MASK = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   axi4_lite_regbank_if.slave         s_axi,
   output logic [NUM_CTRL*32-1:0]     ctrl_o,
   input  logic [NUM_STAT*32-1:0]     stat_i,
   output logic [NUM_CTRL-1:0]        wr_pulse_o
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Write-side state
   logic                  r_aw_held;
   logic                  r_w_held;
   logic [ADDR_WIDTH-3:0] r_aw_idx;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic                  r_bvalid;
   logic [1:0]            r_bresp;
   logic [NUM_CTRL*32-1:0] r_ctrl;
   logic [NUM_CTRL-1:0]   r_wr_pulse;

   // Read-side state
   logic                  r_rvalid;
   logic [1:0]            r_rresp;
   logic [31:0]           r_rdata;

   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_ar_hs;
   logic                  w_commit;
   logic [31:0]           w_aw_idx;
   logic [31:0]           w_ar_idx;
   logic                  w_wr_ok;
   logic                  w_rd_ok;
   logic [31:0]           w_rd_data;
   logic [NUM_CTRL*32-1:0] w_ctrl_next;
   logic [NUM_CTRL-1:0]   w_pulse_next;
   logic                  w_unused;

   // Byte-offset address bits carry no information for word registers
   assign w_unused = &{1'b0, s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0]};

   assign s_axi.s_axi_awready = !rst && !r_aw_held;
   assign s_axi.s_axi_wready  = !rst && !r_w_held;
   assign s_axi.s_axi_arready = !rst && (!r_rvalid || s_axi.s_axi_rready);
   assign s_axi.s_axi_bvalid  = r_bvalid;
   assign s_axi.s_axi_bresp   = r_bresp;
   assign s_axi.s_axi_rvalid  = r_rvalid;
   assign s_axi.s_axi_rresp   = r_rresp;
   assign s_axi.s_axi_rdata   = r_rdata;
   assign ctrl_o              = r_ctrl;
   assign wr_pulse_o          = r_wr_pulse;

   assign w_aw_hs  = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
   assign w_w_hs   = s_axi.s_axi_wvalid && s_axi.s_axi_wready;
   assign w_ar_hs  = s_axi.s_axi_arvalid && s_axi.s_axi_arready;
   // A pending response that the master is taking this edge frees the slot
   assign w_commit = r_aw_held && r_w_held && (!r_bvalid || s_axi.s_axi_bready);

   assign w_aw_idx = 32'(r_aw_idx);
   assign w_ar_idx = 32'(s_axi.s_axi_araddr[ADDR_WIDTH-1:2]);
   assign w_wr_ok  = w_aw_idx < 32'(NUM_CTRL);
   assign w_rd_ok  = w_ar_idx < 32'(NUM_CTRL + NUM_STAT);

   // Next control-register image: pulse bits decay, committed lanes overwrite
   always_comb begin
      w_ctrl_next  = r_ctrl & ~PULSE_MASK;
      w_pulse_next = '0;
      if (w_commit) begin
         for (int k = 0; k < NUM_CTRL; k++) begin
            if (w_aw_idx == 32'(k)) begin
               w_pulse_next[k] = 1'b1;
               for (int b = 0; b < 4; b++) begin
                  if (r_wstrb[b]) begin
                     w_ctrl_next[k*32 + b*8 +: 8] = r_wdata[b*8 +: 8];
                  end
               end
            end
         end
      end
   end

   // Read mux over control and status words; out-of-range reads return zero
   always_comb begin
      w_rd_data = '0;
      for (int k = 0; k < NUM_CTRL; k++) begin
         if (w_ar_idx == 32'(k)) w_rd_data = r_ctrl[k*32 +: 32];
      end
      for (int j = 0; j < NUM_STAT; j++) begin
         if (w_ar_idx == 32'(NUM_CTRL + j)) w_rd_data = stat_i[j*32 +: 32];
      end
   end

   // AW/W holding buffers, commit into control registers and write response
   always_ff @(posedge clk) begin
      if (rst) begin
         r_aw_held  <= 1'b0;
         r_w_held   <= 1'b0;
         r_aw_idx   <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_ctrl     <= '0;
         r_wr_pulse <= '0;
      end else begin
         r_ctrl     <= w_ctrl_next;
         r_wr_pulse <= w_pulse_next;
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_idx  <= s_axi.s_axi_awaddr[ADDR_WIDTH-1:2];
         end else if (w_commit) begin
            r_aw_held <= 1'b0;
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= s_axi.s_axi_wdata;
            r_wstrb  <= s_axi.s_axi_wstrb;
         end else if (w_commit) begin
            r_w_held <= 1'b0;
         end
         if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (r_bvalid && s_axi.s_axi_bready) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // Read response register, held while the master stalls rready
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rvalid <= 1'b0;
         r_rresp  <= RESP_OKAY;
         r_rdata  <= '0;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
         r_rdata  <= w_rd_data;
      end else if (r_rvalid && s_axi.s_axi_rready) begin
         r_rvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi4_lite_regbank.sv
// Directed bench for axi4_lite_regbank: writes, strobes, pulse bits, error
// responses, back-pressure and reset during a half-received write.
module tb_axi4_lite_regbank;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] ctrl_o;
   logic [63:0]  stat_i;
   logic [3:0]   wr_pulse_o;
   logic [127:0] snap;
   int           n_cmp = 0;
   int           n_err = 0;

   axi4_lite_regbank_if #(.ADDR_WIDTH(8)) bus ();

   axi4_lite_regbank #(
      .ADDR_WIDTH (8),
      .NUM_CTRL   (4),
      .NUM_STAT   (2),
      .PULSE_MASK (128'h3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_axi      (bus),
      .ctrl_o     (ctrl_o),
      .stat_i     (stat_i),
      .wr_pulse_o (wr_pulse_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // AW and W presented together, accepted on the next edge
   task automatic wr_issue(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      bus.s_axi_awaddr  = a;
      bus.s_axi_awvalid = 1'b1;
      bus.s_axi_wdata   = d;
      bus.s_axi_wstrb   = s;
      bus.s_axi_wvalid  = 1'b1;
      tick();
      bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wvalid  = 1'b0;
   endtask

   task automatic rd_issue(input logic [7:0] a);
      bus.s_axi_araddr  = a;
      bus.s_axi_arvalid = 1'b1;
      tick();
      bus.s_axi_arvalid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      stat_i = {32'hCAFE0001, 32'hA5A55A5A};
      bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 1'b0;
      bus.s_axi_wdata = '0;  bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 1'b0;
      bus.s_axi_bready = 1'b1;
      bus.s_axi_araddr = '0; bus.s_axi_arvalid = 1'b0;
      bus.s_axi_rready = 1'b1;
      tick(); tick(); tick();

      // Reset state
      chk("rst_ctrl", ctrl_o, 128'h0);
      chk("rst_awready", 128'(bus.s_axi_awready), 128'h0);
      chk("rst_wready", 128'(bus.s_axi_wready), 128'h0);
      chk("rst_arready", 128'(bus.s_axi_arready), 128'h0);
      chk("rst_bvalid", 128'(bus.s_axi_bvalid), 128'h0);
      chk("rst_rvalid", 128'(bus.s_axi_rvalid), 128'h0);
      chk("rst_rdata", 128'(bus.s_axi_rdata), 128'h0);
      chk("rst_pulse", 128'(wr_pulse_o), 128'h0);
      rst = 1'b0;
      tick();
      chk("post_rst_readies", 128'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}), 128'h7);

      // Write 0xDEADBEEF to 0x04, AW and W together
      wr_issue(8'h04, 32'hDEADBEEF, 4'hF);
      chk("t1_readies_held", 128'({bus.s_axi_awready, bus.s_axi_wready}), 128'h0);
      chk("t1_bvalid_early", 128'(bus.s_axi_bvalid), 128'h0);
      tick();
      chk("t1_ctrl1", 128'(ctrl_o[63:32]), 128'hDEADBEEF);
      chk("t1_bvalid", 128'(bus.s_axi_bvalid), 128'h1);
      chk("t1_bresp", 128'(bus.s_axi_bresp), 128'h0);
      chk("t1_pulse", 128'(wr_pulse_o), 128'h2);
      tick();
      chk("t1_pulse_gone", 128'(wr_pulse_o), 128'h0);
      chk("t1_bvalid_gone", 128'(bus.s_axi_bvalid), 128'h0);
      rd_issue(8'h04);
      chk("t1_rvalid", 128'(bus.s_axi_rvalid), 128'h1);
      chk("t1_rdata", 128'(bus.s_axi_rdata), 128'hDEADBEEF);
      chk("t1_rresp", 128'(bus.s_axi_rresp), 128'h0);
      tick();
      chk("t1_rvalid_gone", 128'(bus.s_axi_rvalid), 128'h0);

      // W two cycles ahead of AW, partial strobes on 0x08
      bus.s_axi_wdata = 32'h11223344; bus.s_axi_wstrb = 4'b0101; bus.s_axi_wvalid = 1'b1;
      tick();
      bus.s_axi_wvalid = 1'b0;
      chk("t2_wready_held", 128'(bus.s_axi_wready), 128'h0);
      chk("t2_awready_a", 128'(bus.s_axi_awready), 128'h1);
      tick();
      chk("t2_awready_b", 128'(bus.s_axi_awready), 128'h1);
      chk("t2_no_commit", 128'(bus.s_axi_bvalid), 128'h0);
      bus.s_axi_awaddr = 8'h08; bus.s_axi_awvalid = 1'b1;
      tick();
      bus.s_axi_awvalid = 1'b0;
      tick();
      chk("t2_ctrl2", 128'(ctrl_o[95:64]), 128'h00220044);
      chk("t2_bvalid", 128'(bus.s_axi_bvalid), 128'h1);
      chk("t2_pulse", 128'(wr_pulse_o), 128'h4);
      tick();
      rd_issue(8'h08);
      chk("t2_rdata", 128'(bus.s_axi_rdata), 128'h00220044);

      // Read and write of 0x08 on the same edge: read sees the old value
      wr_issue(8'h08, 32'h99999999, 4'hF);
      bus.s_axi_araddr = 8'h08; bus.s_axi_arvalid = 1'b1;
      tick();
      bus.s_axi_arvalid = 1'b0;
      chk("rw_rdata_old", 128'(bus.s_axi_rdata), 128'h00220044);
      chk("rw_ctrl_new", 128'(ctrl_o[95:64]), 128'h99999999);
      tick();

      // Pulse bits 1:0 of register 0
      wr_issue(8'h00, 32'h00000003, 4'hF);
      tick();
      chk("t3_pulse_hi", 128'(ctrl_o[1:0]), 128'h3);
      chk("t3_wr_pulse", 128'(wr_pulse_o), 128'h1);
      tick();
      chk("t3_pulse_lo", 128'(ctrl_o[1:0]), 128'h0);
      rd_issue(8'h00);
      chk("t3_rdata", 128'(bus.s_axi_rdata), 128'h0);

      // Writes to a status index and to an unmapped index
      snap = ctrl_o;
      wr_issue(8'h10, 32'hFFFFFFFF, 4'hF);
      tick();
      chk("t4_stat_bvalid", 128'(bus.s_axi_bvalid), 128'h1);
      chk("t4_stat_bresp", 128'(bus.s_axi_bresp), 128'h2);
      chk("t4_stat_pulse", 128'(wr_pulse_o), 128'h0);
      chk("t4_stat_ctrl", ctrl_o, snap);
      tick();
      wr_issue(8'hFC, 32'hFFFFFFFF, 4'hF);
      tick();
      chk("t4_oor_bresp", 128'(bus.s_axi_bresp), 128'h2);
      chk("t4_oor_pulse", 128'(wr_pulse_o), 128'h0);
      chk("t4_oor_ctrl", ctrl_o, snap);
      tick();
      rd_issue(8'hFC);
      chk("t4_rd_oor_data", 128'(bus.s_axi_rdata), 128'h0);
      chk("t4_rd_oor_resp", 128'(bus.s_axi_rresp), 128'h2);
      rd_issue(8'h10);
      chk("t4_rd_stat0", 128'(bus.s_axi_rdata), 128'hA5A55A5A);
      chk("t4_rd_stat0_resp", 128'(bus.s_axi_rresp), 128'h0);
      rd_issue(8'h14);
      chk("t4_rd_stat1", 128'(bus.s_axi_rdata), 128'hCAFE0001);
      tick();

      // Write-response back-pressure
      bus.s_axi_bready = 1'b0;
      wr_issue(8'h0C, 32'h12345678, 4'hF);
      tick();
      chk("t5_first_commit", 128'(ctrl_o[127:96]), 128'h12345678);
      chk("t5_bvalid", 128'(bus.s_axi_bvalid), 128'h1);
      wr_issue(8'h0C, 32'hAAAAAAAA, 4'hF);
      for (int i = 0; i < 4; i++) begin
         chk("t5_hold_bvalid", 128'(bus.s_axi_bvalid), 128'h1);
         chk("t5_hold_bresp", 128'(bus.s_axi_bresp), 128'h0);
         chk("t5_hold_awready", 128'(bus.s_axi_awready), 128'h0);
         chk("t5_hold_ctrl", 128'(ctrl_o[127:96]), 128'h12345678);
         chk("t5_hold_pulse", 128'(wr_pulse_o), 128'h0);
         tick();
      end
      bus.s_axi_bready = 1'b1;
      tick();
      chk("t5_second_commit", 128'(ctrl_o[127:96]), 128'hAAAAAAAA);
      chk("t5_bvalid_again", 128'(bus.s_axi_bvalid), 128'h1);
      chk("t5_pulse", 128'(wr_pulse_o), 128'h8);
      tick();
      chk("t5_bvalid_done", 128'(bus.s_axi_bvalid), 128'h0);

      // Read-data back-pressure
      bus.s_axi_rready = 1'b0;
      rd_issue(8'h0C);
      chk("t5_r_rdata", 128'(bus.s_axi_rdata), 128'hAAAAAAAA);
      bus.s_axi_araddr = 8'h04; bus.s_axi_arvalid = 1'b1;
      chk("t5_r_arready", 128'(bus.s_axi_arready), 128'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_r_hold_valid", 128'(bus.s_axi_rvalid), 128'h1);
         chk("t5_r_hold_data", 128'(bus.s_axi_rdata), 128'hAAAAAAAA);
      end
      bus.s_axi_rready = 1'b1;
      tick();
      bus.s_axi_arvalid = 1'b0;
      chk("t5_r_next_valid", 128'(bus.s_axi_rvalid), 128'h1);
      chk("t5_r_next_data", 128'(bus.s_axi_rdata), 128'hDEADBEEF);
      tick();
      chk("t5_r_done", 128'(bus.s_axi_rvalid), 128'h0);

      // Reset with AW held and W still missing
      bus.s_axi_awaddr = 8'h04; bus.s_axi_awvalid = 1'b1;
      tick();
      bus.s_axi_awvalid = 1'b0;
      chk("t6_aw_held", 128'(bus.s_axi_awready), 128'h0);
      rst = 1'b1;
      tick();
      chk("t6_ctrl_zero", ctrl_o, 128'h0);
      chk("t6_readies_low", 128'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}), 128'h0);
      rst = 1'b0;
      tick();
      chk("t6_readies_high", 128'({bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_arready}), 128'h7);
      bus.s_axi_wdata = 32'h55555555; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
      tick();
      bus.s_axi_wvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t6_no_bvalid", 128'(bus.s_axi_bvalid), 128'h0);
         chk("t6_ctrl_still_zero", ctrl_o, 128'h0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi4_lite_regbank.md
# axi4_lite_regbank

Parametrised AXI4-Lite slave register bank that succeeds the two-register control/config slave. It holds NUM_CTRL read/write control registers and NUM_STAT read-only status registers. Write address and write data are accepted independently, responses are held until the master takes them, and out-of-range or illegal writes return SLVERR. Per-bit self-clearing pulse fields and per-register write strobes are generated for the processing datapath.

## Interface
- ADDR_WIDTH, 8: width of awaddr/araddr. Word index is addr[ADDR_WIDTH-1:2]; bits [1:0] are ignored.
- NUM_CTRL, 4: number of RW control registers, at word indices 0..NUM_CTRL-1.
- NUM_STAT, 2: number of RO status registers, at word indices NUM_CTRL..NUM_CTRL+NUM_STAT-1.
- PULSE_MASK, 0: NUM_CTRL*32-bit mask. A bit set to 1 is self-clearing: it is high for exactly one cycle after it is written to 1.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_axi_awaddr  in  ADDR_WIDTH; s_axi_awvalid in 1; s_axi_awready out 1
- s_axi_wdata  in  32; s_axi_wstrb in 4; s_axi_wvalid in 1; s_axi_wready out 1
- s_axi_bresp  out  2; s_axi_bvalid out 1; s_axi_bready in 1
- s_axi_araddr  in  ADDR_WIDTH; s_axi_arvalid in 1; s_axi_arready out 1
- s_axi_rdata  out  32; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1
- ctrl_o  out  NUM_CTRL*32  control registers; register k occupies bits [32k+31:32k].
- stat_i  in  NUM_STAT*32  status words; status j is read at index NUM_CTRL+j.
- wr_pulse_o  out  NUM_CTRL  one-cycle strobe per control register on each committed write.

## Operation
- Write path: separate AW and W holding buffers, each with a held flag.
  - s_axi_awready = !rst & !aw_held.
  - s_axi_wready = !rst & !w_held.
  - A buffer loads on its own valid&ready edge. AW and W may arrive in either order or together.
- Commit happens on the first edge where aw_held & w_held & (!bvalid | bready). On that edge:
  - For an RW index, each byte lane whose wstrb bit is 1 is written into ctrl_o. wr_pulse_o[idx] is set for one cycle. bresp = 2'b00.
  - For an RO or out-of-range index, no register changes, no wr_pulse_o. bresp = 2'b10 (SLVERR).
  - bvalid is set, and both held flags clear.
- bvalid/bresp stay stable until bvalid & bready, then bvalid drops on that edge unless a new commit sets it again on the same edge.
- Self-clearing bits: a PULSE_MASK bit written to 1 reads 1 in ctrl_o for one cycle, then returns to 0 on the next edge. A write of 0 has no effect. Non-pulse bits hold their value until rewritten.
- Read path: s_axi_arready = !rst & (!rvalid | rready). On the AR handshake edge:
  - rdata is loaded with the ctrl register value, the stat_i word sampled on that edge, or 0 for out-of-range.
  - rresp is 2'b00, or 2'b10 for out-of-range.
  - rvalid is set.
- rdata/rresp/rvalid are held stable while rvalid & !rready.
- Read and write to the same register on the same edge: the read returns the pre-write value.
- Reset while rst is high:
  - All ctrl registers = 0, wr_pulse_o = 0.
  - Held flags cleared, bvalid = rvalid = 0, bresp = rresp = 0, rdata = 0.
  - All ready outputs = 0.
  - An in-flight transaction is dropped and gets no response.

## Timing
- Write latency: both buffers loaded by edge E0 → commit at edge E1. ctrl_o, bvalid and wr_pulse_o are all visible in the cycle after E1. A pulse bit reads 1 in that cycle and 0 after E2.
- Sustained writes with bready held 1: one write per 2 cycles. The ready signal is low for the cycle in which its buffer is held.
- Back-pressure: when bready = 0 and bvalid = 1, the held buffers stay occupied and awready/wready stay 0. No commit happens, so no register change.
- Read latency: rvalid is high in the cycle after the AR handshake. With rready held 1, one read per cycle back-to-back.
- First cycle after rst falls: awready = wready = arready = 1.

## Test plan
- Write 0xDEADBEEF to 0x04 with AW and W in the same cycle, bready = 1 → ctrl_o[63:32] = 0xDEADBEEF, bvalid one cycle after commit, bresp = 0, wr_pulse_o = 4'b0010 for one cycle; a read of 0x04 returns 0xDEADBEEF with rresp = 0.
- W two cycles before AW, wstrb = 4'b0101, wdata = 0x11223344 on a register holding 0 → register reads 0x00220044; awready stays 1 until the AW handshake.
- PULSE_MASK = 3, write 0x3 to 0x00 → ctrl_o[1:0] = 2'b11 for exactly one cycle, then 2'b00; a subsequent read of 0x00 returns 0.
- Write to a status index (0x10) and to 0xFC → bresp = 2'b10, no ctrl_o change, no wr_pulse_o; a read of 0xFC gives rdata = 0, rresp = 2'b10; a read of 0x10 returns stat_i[31:0].
- Hold bready = 0 for 5 cycles after bvalid rises, then send a second AW/W → bvalid/bresp stay stable, the second write does not commit until bready is seen, and the rready = 0 hold case keeps rdata stable.
- Assert rst mid-write, with AW held but W not yet received → all ctrl_o = 0, no bvalid ever issued, readies = 1 the cycle after rst falls.
